// File: rtl/pio_poll_pkg.sv
// Shared constants, FSM encoding and event packing for pio_poll_ctrl.
// POLL_DEBOUNCE_EN is consumed by pio_poll_ctrl, not by this package.
package pio_poll_pkg;

  localparam logic [1:0] ADDR_STATUS = 2'd0;
  localparam logic [1:0] ADDR_EVENT  = 2'd1;
  localparam logic [1:0] ADDR_PERIOD = 2'd2;
  localparam logic [1:0] ADDR_CTRL   = 2'd3;

  localparam int EV_NEW_LSB  = 0;
  localparam int EV_PREV_LSB = 2;
  localparam int EV_TS_LSB   = 16;

  localparam int STS_COUNT_LSB = 0;
  localparam int STS_EMPTY     = 8;
  localparam int STS_FULL      = 9;
  localparam int STS_OVF       = 10;
  localparam int STS_DEB       = 11;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_IRQ_EN  = 1;
  localparam int CTRL_OVF_CLR = 2;

  localparam int CNT_W = 5;

  localparam logic [1:0] PIO_DATA_ADDR = 2'd0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_WAIT,
    ST_CAPTURE
  } poll_state_e;

  function automatic logic [31:0] pack_event(
    input logic [15:0] ts,
    input logic [1:0]  prev,
    input logic [1:0]  nv
  );
    logic [31:0] w;
    w = '0;
    w[EV_TS_LSB +: 16]  = ts;
    w[EV_PREV_LSB +: 2] = prev;
    w[EV_NEW_LSB +: 2]  = nv;
    return w;
  endfunction

endpackage

// File: rtl/pio_poll_fifo.sv
// Synchronous event FIFO; a pop and push in the same cycle when full
// both succeed, so a full FIFO can still accept while draining.
module pio_poll_fifo
  import pio_poll_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_push,
  input  logic [W-1:0]     i_wdata,
  input  logic             i_pop,
  output logic [W-1:0]     o_rdata,
  output logic             o_full,
  output logic             o_empty,
  output logic [CNT_W-1:0] o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [AW:0]   r_cnt;
  logic          w_pop_ok;
  logic          w_push_ok;

  assign o_full    = (r_cnt == FULL_CNT);
  assign o_empty   = (r_cnt == '0);
  assign o_count   = CNT_W'(r_cnt);
  assign o_rdata   = r_mem[r_rd];
  assign w_pop_ok  = i_pop & ~o_empty;
  assign w_push_ok = i_push & (~o_full | w_pop_ok);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push_ok) begin
        r_mem[r_wr] <= i_wdata;
        r_wr        <= r_wr + 1'b1;
      end
      if (w_pop_ok) r_rd <= r_rd + 1'b1;
      r_cnt <= r_cnt + {{AW{1'b0}}, w_push_ok}
                     - {{AW{1'b0}}, w_pop_ok};
    end
  end

endmodule

// File: rtl/pio_poll_ctrl.sv
// Periodic 2-bit PIO poller with change-event FIFO and host IRQ.
// Define POLL_DEBOUNCE_EN to require two matching captures per change.
module pio_poll_ctrl
  import pio_poll_pkg::*;
#(
  parameter int          DEPTH          = 4,
  parameter logic [15:0] DEFAULT_PERIOD = 16'd1000,
  parameter int          PIO_LATENCY    = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [1:0]  pio_address,
  input  logic [31:0] pio_readdata,
  input  logic [1:0]  s_address,
  input  logic        s_read,
  input  logic        s_write,
  input  logic [31:0] s_writedata,
  output logic [31:0] s_readdata,
  output logic        irq
);

  localparam logic [3:0] WAIT_LAST = 4'(PIO_LATENCY - 1);
`ifdef POLL_DEBOUNCE_EN
  localparam logic DEB_EN = 1'b1;
`else
  localparam logic DEB_EN = 1'b0;
`endif

  poll_state_e r_state;
  poll_state_e w_next;

  logic [15:0] r_period;
  logic        r_enable;
  logic        r_irq_en;
  logic        r_en_d;
  logic [15:0] r_timer;
  logic [3:0]  r_wait;
  logic [1:0]  r_base;
  logic        r_bvalid;
  logic [15:0] r_ts;
  logic        r_ovf;
  logic        r_irq;
  logic [31:0] r_rdata;

  logic [15:0]      w_reload;
  logic             w_en_rise;
  logic             w_expire;
  logic             w_capture;
  logic             w_wait_run;
  logic [1:0]       w_pio_addr;
  logic [1:0]       w_sample;
  logic             w_diff;
  logic             w_accept;
  logic             w_push;
  logic             w_pop;
  logic             w_ovf_clr;
  logic             w_drop;
  logic [31:0]      w_fifo_rd;
  logic             w_full;
  logic             w_empty;
  logic [CNT_W-1:0] w_count;
  logic [31:0]      w_rd_mux;
  logic             w_unused;

  assign w_unused  = ^{pio_readdata[31:2], s_writedata[31:16]};
  assign w_sample  = pio_readdata[1:0];
  assign w_reload  = (r_period == 16'd0) ? 16'd1 : r_period;
  assign w_en_rise = r_enable & ~r_en_d;
  assign w_expire  = r_enable & ~w_en_rise & (r_timer <= 16'd1);
  assign w_pop     = s_read & (s_address == ADDR_EVENT);
  assign w_ovf_clr = s_write & (s_address == ADDR_CTRL)
                   & s_writedata[CTRL_OVF_CLR];
  assign w_push    = w_capture & r_enable & r_bvalid & w_accept;
  assign w_drop    = w_push & w_full & ~(w_pop & ~w_empty);

  assign pio_address = w_pio_addr;
  assign s_readdata  = r_rdata;
  assign irq         = r_irq;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_period <= DEFAULT_PERIOD;
      r_enable <= 1'b0;
      r_irq_en <= 1'b0;
    end else if (s_write) begin
      unique case (s_address)
        ADDR_PERIOD: r_period <= s_writedata[15:0];
        ADDR_CTRL: begin
          r_enable <= s_writedata[CTRL_EN];
          r_irq_en <= s_writedata[CTRL_IRQ_EN];
        end
        default: ;
      endcase
    end
  end

  // Period writes land only at the next reload.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_en_d  <= 1'b0;
      r_timer <= 16'd0;
    end else begin
      r_en_d <= r_enable;
      if (w_en_rise) r_timer <= w_reload;
      else if (r_enable)
        r_timer <= (r_timer <= 16'd1) ? w_reload : r_timer - 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE:    if (w_expire) w_next = ST_ADDR;
      ST_ADDR:    w_next = ST_WAIT;
      ST_WAIT:    if (r_wait == WAIT_LAST) w_next = ST_CAPTURE;
      ST_CAPTURE: w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_pio_addr = PIO_DATA_ADDR;
    w_wait_run = 1'b0;
    w_capture  = 1'b0;
    unique case (r_state)
      ST_WAIT:    w_wait_run = 1'b1;
      ST_CAPTURE: w_capture  = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)         r_wait <= 4'd0;
    else if (!w_wait_run) r_wait <= 4'd0;
    else                  r_wait <= r_wait + 4'd1;
  end

`ifdef POLL_DEBOUNCE_EN
  logic [1:0] r_cand;
  logic       r_cand_v;

  always_comb begin
    w_diff   = (w_sample != r_base);
    w_accept = w_diff & r_cand_v & (r_cand == w_sample);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cand   <= 2'd0;
      r_cand_v <= 1'b0;
    end else if (!r_enable) begin
      r_cand_v <= 1'b0;
    end else if (w_capture & r_bvalid) begin
      if (!w_diff || w_accept) begin
        r_cand_v <= 1'b0;
      end else begin
        r_cand   <= w_sample;
        r_cand_v <= 1'b1;
      end
    end
  end
`else
  always_comb begin
    w_diff   = (w_sample != r_base);
    w_accept = w_diff;
  end
`endif

  // A capture while disabled only advances the timestamp.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_base   <= 2'd0;
      r_bvalid <= 1'b0;
      r_ts     <= 16'd0;
    end else begin
      if (w_capture) r_ts <= r_ts + 16'd1;
      if (!r_enable) begin
        r_bvalid <= 1'b0;
      end else if (w_capture) begin
        if (!r_bvalid) begin
          r_base   <= w_sample;
          r_bvalid <= 1'b1;
        end else if (w_push) begin
          r_base <= w_sample;
        end
      end
    end
  end

  pio_poll_fifo #(
    .DEPTH (DEPTH),
    .W     (32)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .i_push  (w_push),
    .i_wdata (pack_event(r_ts, r_base, w_sample)),
    .i_pop   (w_pop),
    .o_rdata (w_fifo_rd),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_comb begin
    w_rd_mux = '0;
    unique case (s_address)
      ADDR_STATUS: begin
        w_rd_mux[STS_COUNT_LSB +: CNT_W] = w_count;
        w_rd_mux[STS_EMPTY] = w_empty;
        w_rd_mux[STS_FULL]  = w_full;
        w_rd_mux[STS_OVF]   = r_ovf;
        w_rd_mux[STS_DEB]   = DEB_EN;
      end
      ADDR_EVENT:  w_rd_mux = w_empty ? 32'd0 : w_fifo_rd;
      ADDR_PERIOD: w_rd_mux[15:0] = r_period;
      ADDR_CTRL: begin
        w_rd_mux[CTRL_EN]     = r_enable;
        w_rd_mux[CTRL_IRQ_EN] = r_irq_en;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ovf   <= 1'b0;
      r_irq   <= 1'b0;
      r_rdata <= 32'd0;
    end else begin
      r_ovf <= (r_ovf & ~w_ovf_clr) | w_drop;
      r_irq <= r_irq_en & (~w_empty | r_ovf);
      if (s_read) r_rdata <= w_rd_mux;
    end
  end

endmodule

// File: tb/tb_pio_poll_ctrl.sv
// Directed scoreboard bench for pio_poll_ctrl (DEPTH 4, PIO_LATENCY 1).
// Expected events are queued when the input changes and popped on EVENT reads.
module tb_pio_poll_ctrl;
  import pio_poll_pkg::*;

`ifdef POLL_DEBOUNCE_EN
  localparam int DEB = 1;
`else
  localparam int DEB = 0;
`endif
  localparam int DEPTH_TB = 4;
  localparam logic [31:0] TS_MASK = 32'h0000_FFFF;
  localparam logic [31:0] ALL     = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  pio_address;
  logic [31:0] pio_readdata = '0;
  logic [1:0]  s_address = '0;
  logic        s_read = 1'b0;
  logic        s_write = 1'b0;
  logic [31:0] s_writedata = '0;
  logic [31:0] s_readdata;
  logic        irq;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int cyc0 = 0;

  logic [31:0] sb_q[$];
  logic [31:0] sb_m[$];
  int          m_cnt = 0;
  logic        m_ovf = 1'b0;
  logic [1:0]  m_prev = 2'd0;

  pio_poll_ctrl #(
    .DEPTH          (DEPTH_TB),
    .DEFAULT_PERIOD (16'd1000),
    .PIO_LATENCY    (1)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .pio_address  (pio_address),
    .pio_readdata (pio_readdata),
    .s_address    (s_address),
    .s_read       (s_read),
    .s_write      (s_write),
    .s_writedata  (s_writedata),
    .s_readdata   (s_readdata),
    .irq          (irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] req);
    checks++;
    assert (obs === req) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, req);
    end
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
    s_address = a; s_writedata = d; s_write = 1'b1;
    @(negedge clk);
    s_write = 1'b0;
  endtask

  task automatic bus_rd(input logic [1:0] a, output logic [31:0] d);
    s_address = a; s_read = 1'b1;
    @(negedge clk);
    s_read = 1'b0;
    d = s_readdata;
  endtask

  task automatic wait_abs(input int k);
    while ((cyc - cyc0) < k) @(negedge clk);
  endtask

  task automatic wait_ofs(input int m);
    for (int i = 0; i < 4 && ((cyc - cyc0) % 4) != m; i++)
      @(negedge clk);
  endtask

  function automatic logic [31:0] status_exp();
    logic [31:0] s;
    s = '0;
    s[4:0] = 5'(m_cnt);
    s[8]   = (m_cnt == 0);
    s[9]   = (m_cnt == DEPTH_TB);
    s[10]  = m_ovf;
    s[11]  = (DEB != 0);
    return s;
  endfunction

  task automatic sb_push(input int ts, input logic [1:0] pv,
                         input logic [1:0] nv, input logic [31:0] mask);
    if (m_cnt < DEPTH_TB) begin
      sb_q.push_back(pack_event(16'(ts), pv, nv));
      sb_m.push_back(mask);
      m_cnt++;
    end else begin
      m_ovf = 1'b1;
    end
  endtask

  task automatic pop_check(input string tag);
    logic [31:0] d, e, mk;
    bus_rd(ADDR_EVENT, d);
    if (sb_q.size() == 0) begin
      check(tag, d, 32'd0);
    end else begin
      e = sb_q.pop_front();
      mk = sb_m.pop_front();
      m_cnt--;
      check(tag, d & mk, e & mk);
    end
  endtask

  // Change lands at the capture two cycles ahead (ts=(o-6)/4), or one later.
  task automatic drive_val(input logic [1:0] v, input logic [31:0] mask,
                           output int o);
    wait_ofs(2);
    o = cyc - cyc0;
    pio_readdata = {30'd0, v};
    sb_push((o - 6) / 4 + DEB, m_prev, v, mask);
    m_prev = v;
  endtask

  initial begin
    logic [31:0] d;
    int o;
    logic [1:0] vals3 [5];
    logic [1:0] vals4 [4];
    vals3 = '{2'd0, 2'd1, 2'd0, 2'd1, 2'd0};
    vals4 = '{2'd1, 2'd0, 2'd1, 2'd0};

    repeat (3) @(negedge clk);
    check("rst_pio_address", {30'd0, pio_address}, 32'd0);
    check("rst_s_readdata", s_readdata, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    bus_rd(ADDR_STATUS, d); check("rst_status", d, status_exp());
    bus_rd(ADDR_PERIOD, d); check("rst_period", d, 32'd1000);
    bus_rd(ADDR_CTRL, d);   check("rst_ctrl", d, 32'd0);

    // Test 1: baseline capture, no event
    bus_wr(ADDR_PERIOD, 32'd4);
    bus_wr(ADDR_CTRL, 32'd1);
    cyc0 = cyc;
    wait_abs(5);
    check("t1_addr_in_ADDR", {30'd0, pio_address}, 32'd0);
    wait_abs(10);
    pio_readdata = 32'd2;
    bus_rd(ADDR_STATUS, d); check("t1_status_baseline", d, status_exp());

    // Test 2: 0 -> 2 change
    sb_push(1 + DEB, 2'd0, 2'd2, ALL);
    m_prev = 2'd2;
    wait_abs(14 + 4 * DEB);
    bus_rd(ADDR_STATUS, d); check("t2_status_one", d, status_exp());
    pop_check("t2_event");
    bus_rd(ADDR_STATUS, d); check("t2_status_drained", d, status_exp());
    pop_check("t2_event_empty");

    // Test 3: five changes into a 4-deep FIFO
    bus_wr(ADDR_CTRL, 32'd3);
    foreach (vals3[i]) begin
      drive_val(vals3[i], ALL, o);
      repeat (4 * (1 + DEB)) @(negedge clk);
    end
    repeat (4) @(negedge clk);
    bus_rd(ADDR_STATUS, d); check("t3_status_ovf", d, status_exp());
    check("t3_irq_set", {31'd0, irq}, 32'd1);
    bus_wr(ADDR_CTRL, 32'd6);
    m_ovf = 1'b0;
    bus_rd(ADDR_STATUS, d); check("t3_status_clr", d, status_exp());
    check("t3_irq_held", {31'd0, irq}, 32'd1);
    bus_rd(ADDR_CTRL, d); check("t3_ctrl_rb", d, 32'd2);
    for (int i = 0; i < 4; i++) pop_check("t3_drain");
    @(negedge clk);
    check("t3_irq_drained", {31'd0, irq}, 32'd0);

    // Test 4: pop and push in the same cycle while full
    bus_wr(ADDR_CTRL, 32'd1);
    cyc0 = cyc;
    wait_abs(9);
    foreach (vals4[i]) begin
      drive_val(vals4[i], TS_MASK, o);
      repeat (4 * (1 + DEB)) @(negedge clk);
    end
    bus_rd(ADDR_STATUS, d); check("t4_status_full", d, status_exp());
    wait_ofs(2);
    o = cyc - cyc0;
    pio_readdata = 32'd1;
    wait_abs(o + 1 + 4 * DEB);
    pop_check("t4_pop_oldest");
    sb_push(0, m_prev, 2'd1, TS_MASK);
    m_prev = 2'd1;
    repeat (3) @(negedge clk);
    bus_rd(ADDR_STATUS, d); check("t4_status_same", d, status_exp());

    // Test 5: asynchronous reset in WAIT
    bus_wr(ADDR_CTRL, 32'd3);
    @(negedge clk);
    check("t5_irq_pre", {31'd0, irq}, 32'd1);
    bus_rd(ADDR_STATUS, d); check("t5_status_pre", d, status_exp());
    wait_ofs(2);
    #2 reset_n = 1'b0;
    #1;
    check("t5_async_pio_address", {30'd0, pio_address}, 32'd0);
    check("t5_async_s_readdata", s_readdata, 32'd0);
    check("t5_async_irq", {31'd0, irq}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    sb_q.delete(); sb_m.delete();
    m_cnt = 0; m_ovf = 1'b0;
    @(negedge clk);
    bus_rd(ADDR_STATUS, d); check("t5_status", d, status_exp());
    bus_rd(ADDR_CTRL, d);   check("t5_ctrl", d, 32'd0);
    bus_rd(ADDR_PERIOD, d); check("t5_period", d, 32'd1000);
    pop_check("t5_event_empty");

    // Test 6: one-capture glitch, then a held change
    pio_readdata = 32'd0;
    m_prev = 2'd0;
    bus_wr(ADDR_PERIOD, 32'd4);
    bus_wr(ADDR_CTRL, 32'd1);
    cyc0 = cyc;
    wait_abs(10);
    wait_ofs(2);
    o = cyc - cyc0;
    pio_readdata = 32'd3;
    if (DEB == 0) sb_push((o - 6) / 4, 2'd0, 2'd3, ALL);
    repeat (4) @(negedge clk);
    pio_readdata = 32'd0;
    if (DEB == 0) sb_push((o - 2) / 4, 2'd3, 2'd0, ALL);
    wait_abs(o + 12);
    bus_rd(ADDR_STATUS, d); check("t6_status_glitch", d, status_exp());
    pop_check("t6_glitch_ev0");
    pop_check("t6_glitch_ev1");
    drive_val(2'd3, ALL, o);
    repeat (4 + 4 * DEB) @(negedge clk);
    bus_rd(ADDR_STATUS, d); check("t6_status_held", d, status_exp());
    pop_check("t6_held_event");
    pop_check("t6_final_empty");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
